alu_pipe_act: RTL and testbench

// - Parametrised 2-stage pipelined ALU with valid/ready handshake and registered flags (S,Cr,Ze,P,O).
// - Built-in switching-activity counter: accumulates result-bit toggles for the power-estimation flow.
// - Sits between operand sources and the result sink / activity readout of the estimation accelerator.

---
 rtl/alu_pipe_act.sv | 151 +++++++++++++++
 tb/tb_alu_pipe_act.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_act.sv
// Two-stage pipelined ALU with valid/ready handshake, registered S/Cr/Ze/P/O flags
// and a saturating result-toggle counter feeding the power-estimation flow.
module alu_pipe_act #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             s,
  output logic             cr,
  output logic             ze,
  output logic             p,
  output logic             o,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] act_cnt
);
  localparam int MSB = WIDTH - 1;
  localparam int PW  = $clog2(WIDTH + 1);
  localparam int SW  = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7
  } op_e;

  logic             r_v1, r_v2;
  op_e              r_op;
  logic [WIDTH-1:0] r_x, r_y, r_z;
  logic             r_s, r_cr, r_ze, r_p, r_o;
  logic [CNT_W-1:0] r_cnt;

  logic             w_stall, w_load;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_z, w_tog;
  logic             w_cr, w_o;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_stall  = r_v2 & ~out_ready;
  assign w_load   = r_v1 & ~w_stall;
  assign in_ready = ~w_stall | ~rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_op <= OP_ADD;
      r_x  <= '0;
      r_y  <= '0;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      r_op <= op_e'(op);
      r_x  <= x;
      r_y  <= y;
    end
  end

  always_comb begin
    w_sum = '0;
    w_z   = '0;
    w_cr  = 1'b0;
    w_o   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_x} + {1'b0, r_y};
        w_z   = w_sum[MSB:0];
        w_cr  = w_sum[WIDTH];
        w_o   = (r_x[MSB] == r_y[MSB]) & (w_z[MSB] != r_x[MSB]);
      end
      OP_SUB: begin
        // carry out of x + ~y + 1: set means no borrow
        w_sum = {1'b0, r_x} + {1'b0, ~r_y} + (WIDTH+1)'(1);
        w_z   = w_sum[MSB:0];
        w_cr  = w_sum[WIDTH];
        w_o   = (r_x[MSB] != r_y[MSB]) & (w_z[MSB] != r_x[MSB]);
      end
      OP_AND: w_z = r_x & r_y;
      OP_OR:  w_z = r_x | r_y;
      OP_XOR: w_z = r_x ^ r_y;
      OP_NOT: w_z = ~r_x;
      OP_SHL: begin
        w_z  = {r_x[MSB-1:0], 1'b0};
        w_cr = r_x[MSB];
      end
      OP_SHR: begin
        w_z  = {1'b0, r_x[MSB:1]};
        w_cr = r_x[0];
      end
      default: w_z = '0;
    endcase
  end

  // r_z only changes on valid loads, so it doubles as the previous-result reference
  assign w_tog = w_z ^ r_z;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + PW'(w_tog[i]);
  end

  always_comb begin
    w_cnt_sum = clr_cnt ? '0 : SW'(r_cnt);
    if (w_load) w_cnt_sum = w_cnt_sum + SW'(w_pop);
    w_cnt_nxt = (w_cnt_sum > CMAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_z   <= '0;
      r_s   <= 1'b0;
      r_cr  <= 1'b0;
      r_ze  <= 1'b0;
      r_p   <= 1'b0;
      r_o   <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (!w_stall) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_z  <= w_z;
          r_s  <= w_z[MSB];
          r_cr <= w_cr;
          r_ze <= (w_z == '0);
          r_p  <= ~^w_z;
          r_o  <= w_o;
        end
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign out_valid = r_v2;
  assign z         = r_z;
  assign s         = r_s;
  assign cr        = r_cr;
  assign ze        = r_ze;
  assign p         = r_p;
  assign o         = r_o;
  assign act_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_pipe_act.sv
// Bench for alu_pipe_act: three instances (16/32-bit counter, 16/4-bit counter, 32/32-bit)
// in lock-step against a transaction-level queue model, plus directed corner cases.
module tb_alu_pipe_act;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, clr_cnt;
  logic [2:0]  op;
  logic [15:0] x16, y16;
  logic [31:0] x32, y32;

  logic        ir16, ov16, s16, cr16, ze16, p16, o16;
  logic [15:0] z16;
  logic [31:0] a16;
  logic        irs, ovs, ss, crs, zes, ps, os;
  logic [15:0] zs;
  logic [3:0]  as4;
  logic        ir32, ov32, s32, cr32, ze32, p32, o32;
  logic [31:0] z32;
  logic [31:0] a32;

  alu_pipe_act #(.WIDTH(16), .CNT_W(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .op(op), .x(x16), .y(y16),
    .out_valid(ov16), .out_ready(out_ready), .z(z16), .s(s16), .cr(cr16), .ze(ze16), .p(p16),
    .o(o16), .clr_cnt(clr_cnt), .act_cnt(a16));
  alu_pipe_act #(.WIDTH(16), .CNT_W(4)) dsat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs), .op(op), .x(x16), .y(y16),
    .out_valid(ovs), .out_ready(out_ready), .z(zs), .s(ss), .cr(crs), .ze(zes), .p(ps),
    .o(os), .clr_cnt(clr_cnt), .act_cnt(as4));
  alu_pipe_act #(.WIDTH(32), .CNT_W(32)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .op(op), .x(x32), .y(y32),
    .out_valid(ov32), .out_ready(out_ready), .z(z32), .s(s32), .cr(cr32), .ze(ze32), .p(p32),
    .o(o32), .clr_cnt(clr_cnt), .act_cnt(a32));

  typedef struct packed { logic [31:0] z; logic [4:0] f; } res_t;  // f = {s,cr,ze,p,o}
  typedef struct { res_t r16; res_t r32; int age; } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  res_t m16, m32;
  longint unsigned ma16, ma4, ma32;
  bit   m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result and flags from the arithmetic definition of each op, for any width up to 32.
  function automatic res_t ref_alu(input logic [2:0] opc, input longint unsigned xa,
                                   input longint unsigned ya, input int w);
    longint unsigned mask, xv, yv, full, zz;
    longint sx, sy, sr, lim;
    logic c, ov, sg, zf, pf;
    res_t r;
    mask = (64'd1 << w) - 1;
    xv = xa & mask;
    yv = ya & mask;
    lim = longint'(64'd1 << (w - 1));
    sx = ((xv >> (w - 1)) != 0) ? longint'(xv) - 2 * lim : longint'(xv);
    sy = ((yv >> (w - 1)) != 0) ? longint'(yv) - 2 * lim : longint'(yv);
    c = 1'b0; ov = 1'b0; full = 0;
    case (opc)
      3'd0: begin full = xv + yv; c = ((full >> w) & 1) != 0;
                  sr = sx + sy; ov = (sr >= lim) || (sr < -lim); end
      3'd1: begin full = xv + (~yv & mask) + 1; c = ((full >> w) & 1) != 0;
                  sr = sx - sy; ov = (sr >= lim) || (sr < -lim); end
      3'd2: full = xv & yv;
      3'd3: full = xv | yv;
      3'd4: full = xv ^ yv;
      3'd5: full = ~xv;
      3'd6: begin full = xv << 1; c = ((xv >> (w - 1)) & 1) != 0; end
      default: begin full = xv >> 1; c = (xv & 1) != 0; end
    endcase
    zz = full & mask;
    sg = ((zz >> (w - 1)) & 1) != 0;
    zf = (zz == 0);
    pf = ($countones(zz) % 2) == 0;
    r.z = 32'(zz);
    r.f = {sg, c, zf, pf, ov};
    return r;
  endfunction

  function automatic longint unsigned sat_add(input longint unsigned a, input int b, input int cw);
    longint unsigned mx, sm;
    mx = (64'd1 << cw) - 1;
    sm = a + longint'(b);
    return (sm > mx) ? mx : sm;
  endfunction

  task automatic model_edge();
    bit ov, stall;
    ent_t e;
    m_acc = 1'b0;
    if (!rst_n) begin
      q.delete(); m16 = '0; m32 = '0; ma16 = 0; ma4 = 0; ma32 = 0;
      return;
    end
    ov = (q.size() > 0) && (q[0].age >= 1);
    stall = ov && !out_ready;
    if (clr_cnt) begin ma16 = 0; ma4 = 0; ma32 = 0; end
    if (!stall) begin
      if (ov) void'(q.pop_front());
      foreach (q[i]) begin
        if (q[i].age == 0) begin
          ma16 = sat_add(ma16, $countones(q[i].r16.z ^ m16.z), 32);
          ma4  = sat_add(ma4,  $countones(q[i].r16.z ^ m16.z), 4);
          ma32 = sat_add(ma32, $countones(q[i].r32.z ^ m32.z), 32);
          m16 = q[i].r16;
          m32 = q[i].r32;
        end
        q[i].age++;
      end
      if (in_valid) begin
        e.r16 = ref_alu(op, 64'(x16), 64'(y16), 16);
        e.r32 = ref_alu(op, 64'(x32), 64'(y32), 32);
        e.age = 0;
        q.push_back(e);
        m_acc = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit ov, ir;
    ov = (q.size() > 0) && (q[0].age >= 1);
    ir = !rst_n || !(ov && !out_ready);
    chk("ov16", ov16, ov);
    chk("ir16", ir16, ir);
    chk("z16", z16, m16.z[15:0]);
    chk("f16", {s16, cr16, ze16, p16, o16}, m16.f);
    chk("act16", a16, ma16);
    chk("ovsat", ovs, ov);
    chk("zsat", zs, m16.z[15:0]);
    chk("actsat", as4, ma4);
    chk("ov32", ov32, ov);
    chk("ir32", ir32, ir);
    chk("z32", z32, m32.z);
    chk("f32", {s32, cr32, ze32, p32, o32}, m32.f);
    chk("act32", a32, ma32);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic put(input logic [2:0] o_, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] a2, input logic [31:0] b2);
    in_valid = 1'b1; op = o_; x16 = a; y16 = b; x32 = a2; y32 = b2;
  endtask

  task automatic rnd_beat();
    op  = 3'($urandom_range(0, 7));
    x16 = 16'($urandom); y16 = 16'($urandom);
    x32 = $urandom;      y32 = $urandom;
    if ($urandom_range(0, 7) == 0) begin x16 = 16'h8000; x32 = 32'h7FFF_FFFF; end
    if ($urandom_range(0, 7) == 0) begin y16 = x16; y32 = x32; end
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    op = 3'd0; x16 = '0; y16 = '0; x32 = '0; y32 = '0;
    cyc(); cyc();
    chk("rst_ov", ov16, 1'b0);
    chk("rst_ir", ir16, 1'b1);
    chk("rst_z", z16, 16'h0);
    chk("rst_act", a16, 32'h0);
    rst_n = 1'b1;

    // directed: spec vectors on 16-bit, overflow corners on 32-bit
    put(3'd0, 16'h4F80, 16'h1234, 32'h7FFF_FFFF, 32'h1); cyc();
    put(3'd1, 16'h4E87, 16'h8000, 32'h8000_0000, 32'h1); cyc();
    chk("add_z", z16, 16'h61B4);
    chk("add_f", {s16, cr16, ze16, p16, o16}, 5'b00000);
    chk("add_act", a16, 32'd7);
    chk("add32_f", {s32, cr32, ze32, p32, o32}, 5'b10001);
    put(3'd4, 16'hAA2A, 16'h5555, 32'h0, 32'h0); cyc();
    chk("sub_z", z16, 16'hCE87);
    chk("sub_f", {s16, cr16, ze16, p16, o16}, 5'b10001);
    // 7 + popcount(61B4 ^ CE87 = AF33) = 7 + 10
    chk("sub_act", a16, 32'd17);
    chk("sub32_z", z32, 32'h7FFF_FFFF);
    chk("sub32_f", {s32, cr32, ze32, p32, o32}, 5'b01001);
    put(3'd1, 16'h1234, 16'h1234, 32'h1234, 32'h1234); cyc();
    chk("xor_z", z16, 16'hFF7F);
    chk("xor_f", {s16, cr16, ze16, p16, o16}, 5'b10000);
    in_valid = 1'b0; cyc();
    chk("zero_z", z16, 16'h0000);
    chk("zero_f", {s16, cr16, ze16, p16, o16}, 5'b01110);
    cyc();
    chk("bubble_ov", ov16, 1'b0);
    chk("bubble_z", z16, 16'h0000);

    // four back-to-back beats with the sink stalled for three cycles
    idx = 0;
    rnd_beat();
    for (int c = 0; c < 10; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 4);
      cyc();
      if (c >= 2 && c <= 4) chk("stall_ir", ir16, 1'b0);
      if (m_acc) begin idx++; rnd_beat(); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    // saturation of the 4-bit counter with alternating all-ones / all-zeros results
    for (int k = 0; k < 4; k++) begin
      put(3'd3, (k % 2 == 0) ? 16'hFFFF : 16'h0000, 16'h0, 32'h0, 32'h0); cyc();
    end
    in_valid = 1'b0; cyc(); cyc();
    chk("sat_top", as4, 4'hF);
    put(3'd3, 16'hFFFF, 16'h0, 32'h0, 32'h0); cyc();
    in_valid = 1'b0; clr_cnt = 1'b1; cyc();
    chk("clr_load_sat", as4, 4'hF);
    chk("clr_load_16", a16, 32'd16);
    cyc();
    chk("clr_only_sat", as4, 4'h0);
    chk("clr_only_16", a16, 32'd0);
    clr_cnt = 1'b0;

    // reset with both stages full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin put(3'd0, 16'h1111, 16'h2222, 32'h5, 32'h6); cyc(); end
    rst_n = 1'b0; cyc();
    chk("mrst_ov", ov16, 1'b0);
    chk("mrst_z", z16, 16'h0);
    chk("mrst_act", a16, 32'h0);
    chk("mrst_z32", z32, 32'h0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cyc();
    chk("mrst_after_ov", ov16, 1'b0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      rnd_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
